// File: rtl/stream_gen_src_if.sv
`default_nettype none
// ============================================================================
//  Module   : stream_gen_src_if
//  Brief    : Valid/ready payload stream between the generator and its sink.
//  Revision : 1.0 - initial release
// ============================================================================
interface stream_gen_src_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] data;
    logic              vld;
    logic              rdy;

    // Generator side drives payload and valid, samples ready
    modport master (
        output data,
        output vld,
        input  rdy
    );

    // Sink side samples payload and valid, drives ready
    modport slave (
        input  data,
        input  vld,
        output rdy
    );
endinterface
`default_nettype wire

// File: rtl/stream_gen_src.sv
`default_nettype none
// ============================================================================
//  Module   : stream_gen_src
//  Brief    : Streaming traffic source. Emits an arithmetic payload sequence
//             with an LFSR-shaped valid density, bounded or unbounded runs,
//             early stop with drain of a pending beat.
//  Revision : 1.0 - initial release
// ============================================================================
module stream_gen_src #(
    parameter int          DATA_W     = 16,
    parameter int          RAND_RANGE = 255,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    localparam int         TW         = $clog2(RAND_RANGE + 1)
) (
    input  wire logic              clk,
    input  wire logic              s_rst,
    input  wire logic              start,
    input  wire logic              stop,
    input  wire logic [31:0]       count,
    input  wire logic [DATA_W-1:0] first_data,
    input  wire logic [DATA_W-1:0] incr,
    input  wire logic [TW-1:0]     throughput,
    output logic                   busy,
    output logic                   done,
    output logic [31:0]            sent_cnt,
    stream_gen_src_if.master       m_if
);

    localparam logic [1:0]    c_IDLE  = 2'd0;
    localparam logic [1:0]    c_RUN   = 2'd1;
    localparam logic [1:0]    c_DRAIN = 2'd2;

    localparam logic [TW-1:0] c_RANGE = TW'(RAND_RANGE);
    localparam logic [15:0]   c_TAPS  = 16'hB400;

    logic [1:0]        state_q,    state_d;
    logic              vld_q,      vld_d;
    logic [DATA_W-1:0] data_q,     data_d;
    logic [31:0]       sent_cnt_q, sent_cnt_d;
    logic              done_q,     done_d;
    logic [15:0]       lfsr_q,     lfsr_d;
    logic [DATA_W-1:0] incr_q,     incr_d;
    logic [31:0]       count_q,    count_d;

    logic              w_hs;
    logic              w_final;
    logic              w_decision;
    logic [31:0]       w_sent_inc;

    assign m_if.data = data_q;
    assign m_if.vld  = vld_q;
    assign busy      = (state_q != c_IDLE);
    assign done      = done_q;
    assign sent_cnt  = sent_cnt_q;

    // Handshake qualifiers and the per-cycle valid-density decision
    always_comb begin
        w_hs       = vld_q & m_if.rdy;
        w_sent_inc = sent_cnt_q + 32'd1;
        w_final    = w_hs && (count_q != 32'd0) && (w_sent_inc == count_q);
        if (throughput >= c_RANGE) begin
            w_decision = 1'b1;
        end else if (throughput == '0) begin
            w_decision = lfsr_q[0];
        end else begin
            w_decision = (lfsr_q[TW-1:0] < throughput);
        end
    end

    // Next-state logic: run control, payload sequencing, LFSR stepping
    always_comb begin
        state_d    = state_q;
        vld_d      = vld_q;
        data_d     = data_q;
        sent_cnt_d = sent_cnt_q;
        incr_d     = incr_q;
        count_d    = count_q;
        done_d     = 1'b0;
        lfsr_d     = lfsr_q[0] ? ((lfsr_q >> 1) ^ c_TAPS) : (lfsr_q >> 1);

        case (state_q)
            c_IDLE: begin
                // start outranks a coincident stop; stop alone is a no-op here
                if (start) begin
                    state_d    = c_RUN;
                    data_d     = first_data;
                    sent_cnt_d = 32'd0;
                    incr_d     = incr;
                    count_d    = count;
                    vld_d      = w_decision;
                end
            end
            c_RUN: begin
                if (w_hs) begin
                    sent_cnt_d = w_sent_inc;
                    data_d     = data_q + incr_q;
                end
                if (w_final || (stop && (w_hs || !vld_q))) begin
                    // Nothing left pending: close the run immediately
                    vld_d   = 1'b0;
                    state_d = c_IDLE;
                    done_d  = 1'b1;
                end else if (stop) begin
                    // A beat is on the bus and not yet taken: it must still go out
                    state_d = c_DRAIN;
                end else if (!vld_q || w_hs) begin
                    vld_d = w_decision;
                end
            end
            c_DRAIN: begin
                if (w_hs) begin
                    sent_cnt_d = w_sent_inc;
                    vld_d      = 1'b0;
                    state_d    = c_IDLE;
                    done_d     = 1'b1;
                end
            end
            default: begin
                state_d = c_IDLE;
                vld_d   = 1'b0;
            end
        endcase
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (s_rst) begin
            state_q    <= c_IDLE;
            vld_q      <= 1'b0;
            data_q     <= '0;
            sent_cnt_q <= 32'd0;
            done_q     <= 1'b0;
            lfsr_q     <= LFSR_SEED;
            incr_q     <= '0;
            count_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            vld_q      <= vld_d;
            data_q     <= data_d;
            sent_cnt_q <= sent_cnt_d;
            done_q     <= done_d;
            lfsr_q     <= lfsr_d;
            incr_q     <= incr_d;
            count_q    <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stream_gen_src.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_stream_gen_src
//  Brief    : Directed self-checking bench for stream_gen_src.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stream_gen_src;

    localparam int DATA_W     = 16;
    localparam int RAND_RANGE = 255;
    localparam int TW         = 8;

    logic              clk        = 1'b0;
    logic              s_rst      = 1'b1;
    logic              start      = 1'b0;
    logic              stop       = 1'b0;
    logic [31:0]       count      = 32'd0;
    logic [DATA_W-1:0] first_data = '0;
    logic [DATA_W-1:0] incr       = '0;
    logic [TW-1:0]     throughput = '0;
    logic              busy;
    logic              done;
    logic [31:0]       sent_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference LFSR: 16-bit Galois, taps 0xB400, reloads on reset
    logic [15:0] m_lfsr;

    // Scoreboard state for the long random-ready run
    int          hs_cnt;
    int          seq_err;
    int          dec_err;
    int          cyc;
    logic        done_seen;
    logic [15:0] exp_data;
    logic        exp_v;
    logic        hs;
    logic        v;

    stream_gen_src_if #(.DATA_W(DATA_W)) sg_if ();

    stream_gen_src #(
        .DATA_W     (DATA_W),
        .RAND_RANGE (RAND_RANGE),
        .LFSR_SEED  (16'hACE1)
    ) u_dut (
        .clk        (clk),
        .s_rst      (s_rst),
        .start      (start),
        .stop       (stop),
        .count      (count),
        .first_data (first_data),
        .incr       (incr),
        .throughput (throughput),
        .busy       (busy),
        .done       (done),
        .sent_cnt   (sent_cnt),
        .m_if       (sg_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (s_rst) m_lfsr <= 16'hACE1;
        else       m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [31:0] cnt, input logic [15:0] fd,
                          input logic [15:0] inc, input logic [7:0] thr);
        count      = cnt;
        first_data = fd;
        incr       = inc;
        throughput = thr;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    initial begin
        sg_if.rdy = 1'b0;
        // Reset state
        repeat (2) tick();
        check_eq("rst_vld",  sg_if.vld, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_data", sg_if.data, 0);
        check_eq("rst_cnt",  sent_cnt, 0);
        s_rst = 1'b0;
        tick();

        // Full-rate bounded run: 0x10..0x13, done after last beat
        sg_if.rdy = 1'b1;
        launch(32'd4, 16'h0010, 16'h0001, 8'd255);
        check_eq("r040_busy", busy, 1);
        for (int i = 0; i < 4; i++) begin
            check_eq("r040_vld",  sg_if.vld, 1);
            check_eq("r040_data", sg_if.data, 64'h10 + 64'(i));
            check_eq("r040_nodone", done, 0);
            tick();
        end
        check_eq("r040_done", done, 1);
        check_eq("r040_vld0", sg_if.vld, 0);
        check_eq("r040_cnt",  sent_cnt, 4);
        check_eq("r040_idle", busy, 0);
        tick();
        check_eq("r040_done_pulse", done, 0);
        repeat (3) tick();
        check_eq("r040_cnt_hold", sent_cnt, 4);

        // Backpressure mid-run: five stalled cycles, then lossless resume
        launch(32'd8, 16'h0100, 16'h0003, 8'd255);
        tick();
        tick();
        check_eq("r041_pre", sg_if.data, 16'h0106);
        sg_if.rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("r041_stall_vld",  sg_if.vld, 1);
            check_eq("r041_stall_data", sg_if.data, 16'h0106);
        end
        sg_if.rdy = 1'b1;
        for (int k = 0; k < 6; k++) begin
            check_eq("r041_seq", sg_if.data, 64'h106 + 64'(3 * k));
            check_eq("r041_vld", sg_if.vld, 1);
            tick();
        end
        check_eq("r041_done", done, 1);
        check_eq("r041_cnt",  sent_cnt, 8);

        // Payload wrap
        tick();
        launch(32'd3, 16'hFFFE, 16'h0001, 8'd255);
        check_eq("r042_d0", sg_if.data, 16'hFFFE);
        tick();
        check_eq("r042_d1", sg_if.data, 16'hFFFF);
        tick();
        check_eq("r042_d2", sg_if.data, 16'h0000);
        tick();
        check_eq("r042_done", done, 1);

        // Stop while a beat is stalled: drain it, then finish
        tick();
        sg_if.rdy = 1'b0;
        launch(32'd0, 16'h0050, 16'h0001, 8'd255);
        check_eq("r043_vld", sg_if.vld, 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_eq("r043_drain_busy", busy, 1);
        check_eq("r043_drain_vld",  sg_if.vld, 1);
        check_eq("r043_drain_done", done, 0);
        tick();
        tick();
        check_eq("r043_hold_data", sg_if.data, 16'h0050);
        sg_if.rdy = 1'b1;
        tick();
        check_eq("r043_vld0", sg_if.vld, 0);
        check_eq("r043_done", done, 1);
        check_eq("r043_cnt",  sent_cnt, 1);
        check_eq("r043_idle", busy, 0);
        tick();
        check_eq("r043_novld", sg_if.vld, 0);

        // Reset mid-run at sent_cnt=7; start inside a run is ignored
        launch(32'd0, 16'h0000, 16'h0001, 8'd255);
        for (int i = 0; i < 7; i++) begin
            if (i == 3) begin
                first_data = 16'hAAAA;
                start      = 1'b1;
            end
            tick();
            start = 1'b0;
        end
        check_eq("r029_data", sg_if.data, 16'h0007);
        check_eq("r044_cnt7", sent_cnt, 7);
        s_rst = 1'b1;
        start = 1'b1;
        tick();
        s_rst = 1'b0;
        start = 1'b0;
        check_eq("r044_vld",  sg_if.vld, 0);
        check_eq("r044_busy", busy, 0);
        check_eq("r044_cnt",  sent_cnt, 0);
        check_eq("r044_done", done, 0);
        tick();
        check_eq("r044_nodone", done, 0);
        check_eq("r039_idle",   busy, 0);
        launch(32'd2, 16'h0007, 16'h0002, 8'd255);
        check_eq("r044_d0", sg_if.data, 16'h0007);
        tick();
        check_eq("r044_d1", sg_if.data, 16'h0009);
        tick();
        check_eq("r044_done2", done, 1);
        check_eq("r044_cnt2",  sent_cnt, 2);

        // Stop in IDLE ignored; start+stop together starts; stop with handshake
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_eq("r030_busy", busy, 0);
        check_eq("r030_done", done, 0);
        count = 32'd0; first_data = 16'h0123; incr = 16'h0001; throughput = 8'd255;
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        check_eq("r031_busy", busy, 1);
        check_eq("r031_data", sg_if.data, 16'h0123);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_eq("r027_busy", busy, 0);
        check_eq("r027_done", done, 1);
        check_eq("r027_cnt",  sent_cnt, 1);
        check_eq("r027_vld",  sg_if.vld, 0);

        // Sparse density (threshold compare), then stop
        tick();
        exp_v = (m_lfsr[7:0] < 8'd1);
        launch(32'd0, 16'h0000, 16'h0001, 8'd1);
        check_eq("r024_thr1_vld", sg_if.vld, exp_v);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_eq("r025_busy", busy, 0);
        check_eq("r025_done", done, 1);
        check_eq("r025_cnt",  sent_cnt, exp_v ? 1 : 0);

        // LFSR-bit density, 1000 beats, random ready
        tick();
        sg_if.rdy = 1'b0;
        hs_cnt = 0; seq_err = 0; dec_err = 0; cyc = 0; done_seen = 1'b0;
        exp_v = m_lfsr[0];
        launch(32'd1000, 16'h0000, 16'h0001, 8'd0);
        check_eq("r045_first_vld", sg_if.vld, exp_v);
        exp_data = 16'h0000;
        while (!done_seen && cyc < 20000) begin
            v = sg_if.vld;
            if (v && sg_if.data !== exp_data) seq_err++;
            sg_if.rdy = 1'($urandom_range(0, 1));
            hs = v && sg_if.rdy;
            if (hs && hs_cnt == 999)  exp_v = 1'b0;
            else if (hs || !v)        exp_v = m_lfsr[0];
            else                      exp_v = 1'b1;
            tick();
            cyc++;
            if (hs) begin
                hs_cnt++;
                exp_data = exp_data + 16'h0001;
            end
            if (sg_if.vld !== exp_v) dec_err++;
            if (done) done_seen = 1'b1;
        end
        check_eq("r045_done_seen", done_seen, 1);
        check_eq("r045_hs",        hs_cnt, 1000);
        check_eq("r045_cnt",       sent_cnt, 1000);
        check_eq("r045_seq_err",   seq_err, 0);
        check_eq("r045_vld_err",   dec_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stream_gen_src.md
STREAM_GEN_SRC -- requirements
Module: stream_gen_src

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning payload width.
REQ-002 SHALL have parameter RAND_RANGE, default 255, meaning throughput scale; TW = $clog2(RAND_RANGE+1), TW <= 16.
REQ-003 SHALL have parameter LFSR_SEED, default 16'hACE1, meaning non-zero 16-bit LFSR reset value.
REQ-004 clk  in  1  sole clock, all logic on rising edge.
REQ-005 s_rst  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  single-cycle pulse that launches a run.
REQ-007 stop  in  1  single-cycle pulse that ends a run early.
REQ-008 count  in  32  beats per run, sampled on start; 0 means unlimited.
REQ-009 first_data  in  DATA_W  first payload, sampled on start.
REQ-010 incr  in  DATA_W  payload increment, sampled on start.
REQ-011 throughput  in  TW  vld density: 0 means LFSR bit, >= RAND_RANGE means always, else throughput/RAND_RANGE.
REQ-012 data  out  DATA_W  payload.
REQ-013 vld  out  1  payload valid.
REQ-014 rdy  in  1  downstream ready.
REQ-015 busy  out  1  high when the state is not IDLE.
REQ-016 done  out  1  single-cycle pulse at the end of a run.
REQ-017 sent_cnt  out  32  handshakes in the current or last run.

Function
REQ-018 Handshake: a beat SHALL transfer in each cycle with vld=1 and rdy=1.
REQ-019 Once vld=1 and rdy=0, vld and data SHALL hold unchanged until the handshake, with no exceptions (including stop).
REQ-020 FSM SHALL have states IDLE, RUN and DRAIN.
REQ-021 IDLE -> RUN on start: data<=first_data, sent_cnt<=0, internal incr/count latched, vld<=decision (REQ-024).
REQ-022 RUN, handshake: data<=data+incr mod 2^DATA_W, sent_cnt++.
REQ-023 RUN, handshake on beat count (count!=0): vld<=0, done<=1 the next cycle, state -> IDLE.
REQ-024 RUN, (vld==0 or non-final handshake): vld<=decision; decision is 1 if throughput>=RAND_RANGE, lfsr[0] if throughput==0, else (lfsr[TW-1:0] < throughput).
REQ-025 RUN, stop with vld==0: state -> IDLE, done pulse next cycle, vld stays 0.
REQ-026 RUN, stop with vld==1 and no handshake: state -> DRAIN.
REQ-027 RUN, stop with a handshake in the same cycle: the handshake SHALL count, and then behaviour SHALL follow REQ-025.
REQ-028 DRAIN: vld/data held; on handshake sent_cnt++, vld<=0, state -> IDLE, done pulse; no new vld.
REQ-029 start SHALL be ignored outside IDLE.
REQ-030 stop SHALL be ignored in IDLE.
REQ-031 start and stop asserted together in IDLE: start SHALL win.
REQ-032 LFSR: 16-bit Galois, taps 16'hB400, SHALL advance every non-reset cycle.
REQ-033 Latency: with start at edge N and decision=1, vld=1 and data=first_data SHALL hold from edge N.
REQ-034 Full rate (throughput>=RAND_RANGE, rdy=1) SHALL give one beat per cycle, with no bubble.
REQ-035 sent_cnt SHALL wrap modulo 2^32; with count=0 the run never self-terminates.
REQ-036 data and sent_cnt SHALL hold after a run ends until the next start.

Reset
REQ-037 With s_rst=1 at an edge: state=IDLE, vld=0, done=0, busy=0, data=0, sent_cnt=0, lfsr=LFSR_SEED.
REQ-038 Reset SHALL override all activity mid-run, including a pending vld, and no done is issued.
REQ-039 start SHALL be ignored while s_rst=1.

Verification
REQ-040 throughput=255, rdy=1, count=4, first_data=0x10, incr=1 -> data 0x10,0x11,0x12,0x13 on 4 consecutive cycles; done one cycle after the last beat; sent_cnt=4.
REQ-041 Full rate, rdy=0 for 5 cycles mid-run -> vld=1 and data stable for all 5 cycles; sequence resumes without loss or duplication.
REQ-042 first_data=0xFFFE, incr=1, count=3 -> data 0xFFFE, 0xFFFF, 0x0000.
REQ-043 stop while vld=1 and rdy=0, then rdy=1 after 3 cycles -> the pending beat is delivered, no further vld, done one cycle later.
REQ-044 s_rst pulse mid-run at sent_cnt=7 -> next cycle vld=0, busy=0, sent_cnt=0, no done; a following start runs normally.
REQ-045 throughput=0, count=1000, random rdy -> exactly 1000 handshakes, strictly incrementing data, and vld never drops without a handshake.
